sample_capture: RTL



---
 rtl/sample_capture.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sample_capture.sv
// Logic-analyzer acquisition writer: synchronizes probes, decimates, triggers and
// streams one buffer of samples into the SIPO registers. Optional history fill: LA_PRETRIGGER_EN.
module sample_capture #(
  parameter int CHANNEL_COUNT    = 10,
  parameter int SAMPLE_BUFF_SIZE = 640,
  parameter int DIV_WIDTH        = 16,
  parameter int PRETRIG_DEPTH    = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNEL_COUNT-1:0]            chan_in,
  input  logic [CHANNEL_COUNT-1:0]            chan_enable,
  input  logic [DIV_WIDTH-1:0]                sample_div,
  input  logic [$clog2(CHANNEL_COUNT)-1:0]    trig_chan,
  input  logic [1:0]                          trig_mode,
  input  logic                                arm,
  input  logic                                ack,
  output logic                                shift,
  output logic [CHANNEL_COUNT-1:0]            s_in,
  output logic                                busy,
  output logic                                triggered,
  output logic                                done,
  output logic [$clog2(SAMPLE_BUFF_SIZE+1)-1:0] sample_count
);

  localparam int TW = $clog2(CHANNEL_COUNT);
  localparam int CW = $clog2(SAMPLE_BUFF_SIZE + 1);
`ifdef LA_PRETRIGGER_EN
  localparam int   POST_LEN  = SAMPLE_BUFF_SIZE - PRETRIG_DEPTH;
  localparam logic HIST_FILL = 1'b1;
`else
  localparam int   POST_LEN  = SAMPLE_BUFF_SIZE;
  localparam logic HIST_FILL = 1'b0;
`endif
  localparam logic [CW-1:0] POST_LEN_C = CW'(POST_LEN);

  if (PRETRIG_DEPTH >= SAMPLE_BUFF_SIZE) begin : g_bad_depth
    $error("PRETRIG_DEPTH must be smaller than SAMPLE_BUFF_SIZE");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                   state_r, state_s;
  logic [CHANNEL_COUNT-1:0] sync1_r, sync2_r, samp_s;
  logic [DIV_WIDTH-1:0]     div_cnt_r;
  logic                     running_s, tick_s;
  logic                     prev_r, prev_valid_r;
  logic                     trig_bit_s, chan_ok_s, edge_ok_s, trig_cond_s, trig_ok_s;
  logic                     pre_full_s, arm_accept_s, shift_s;
  logic [CW-1:0]            cnt_s;

  assign samp_s    = sync2_r & chan_enable;
  assign running_s = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
  assign tick_s    = running_s && (div_cnt_r == sample_div);

  // Two-flop synchronizer for the asynchronous probe pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= chan_in;
      sync2_r <= sync1_r;
    end
  end

  // Prescaler: restarts on arm, only counts while an acquisition is live
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= '0;
    end else if (arm_accept_s) begin
      div_cnt_r <= '0;
    end else if (running_s) begin
      div_cnt_r <= tick_s ? '0 : div_cnt_r + DIV_WIDTH'(1);
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  // Trigger channel mux; out-of-range indexes read as a constant 0
  always_comb begin
    trig_bit_s = 1'b0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      trig_bit_s = trig_bit_s | (samp_s[i] & (trig_chan == TW'(i)));
    end
  end

  assign chan_ok_s = ({1'b0, trig_chan} < (TW+1)'(CHANNEL_COUNT));
  assign edge_ok_s = chan_ok_s && prev_valid_r;

  // Trigger condition for the current tick
  always_comb begin
    case (trig_mode)
      2'b00:   trig_cond_s = 1'b1;
      2'b01:   trig_cond_s = edge_ok_s && !prev_r && trig_bit_s;
      2'b10:   trig_cond_s = edge_ok_s && prev_r && !trig_bit_s;
      2'b11:   trig_cond_s = edge_ok_s && (prev_r ^ trig_bit_s);
      default: trig_cond_s = 1'b0;
    endcase
  end

  // Trigger-channel value seen at the previous tick
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r       <= 1'b0;
      prev_valid_r <= 1'b0;
    end else if (arm_accept_s) begin
      prev_r       <= 1'b0;
      prev_valid_r <= 1'b0;
    end else if (tick_s) begin
      prev_r       <= trig_bit_s;
      prev_valid_r <= 1'b1;
    end else begin
      prev_r       <= prev_r;
      prev_valid_r <= prev_valid_r;
    end
  end

`ifdef LA_PRETRIGGER_EN
  localparam int PW = $clog2(PRETRIG_DEPTH + 1);
  logic [PW-1:0] pre_count_r;

  assign pre_full_s = (pre_count_r == PW'(PRETRIG_DEPTH));

  // History-fill counter; the trigger is held off until the history is full
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_count_r <= '0;
    end else if (arm_accept_s) begin
      pre_count_r <= '0;
    end else if ((state_r == ST_ARMED) && tick_s && !pre_full_s) begin
      pre_count_r <= pre_count_r + PW'(1);
    end else begin
      pre_count_r <= pre_count_r;
    end
  end
`else
  assign pre_full_s = 1'b1;
`endif

  assign trig_ok_s = trig_cond_s && pre_full_s;

  // Next-state and strobe decode
  always_comb begin
    state_s      = state_r;
    arm_accept_s = 1'b0;
    shift_s      = 1'b0;
    cnt_s        = sample_count;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          state_s      = ST_ARMED;
          arm_accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        shift_s = tick_s && (trig_ok_s || HIST_FILL);
        if (tick_s && trig_ok_s) begin
          state_s = ST_CAPTURE;
          cnt_s   = CW'(1);
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        // Leaving one cycle after the last strobe puts done after that strobe
        if (sample_count == POST_LEN_C) begin
          state_s = ST_DONE;
        end else if (tick_s) begin
          shift_s = 1'b1;
          cnt_s   = sample_count + CW'(1);
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      shift        <= 1'b0;
      s_in         <= '0;
      busy         <= 1'b0;
      triggered    <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
    end else begin
      state_r      <= state_s;
      shift        <= shift_s;
      s_in         <= shift_s ? samp_s : '0;
      busy         <= (state_s == ST_ARMED) || (state_s == ST_CAPTURE);
      triggered    <= (state_s == ST_CAPTURE) || (state_s == ST_DONE);
      done         <= (state_s == ST_DONE);
      sample_count <= cnt_s;
    end
  end

endmodule
